// File: rtl/hall_filter.sv
// hall_filter: synchronizes and glitch-filters two active-low Hall sensors,
// emits falling-edge pulses and a rotation-stall flag.
// Optional feature macro: HALL_GLITCH_CNT_EN adds the saturating glitch_cnt port.
module hall_filter #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hall_1_raw,
    input  logic        hall_2_raw,
    output logic        hall_1,
    output logic        hall_2,
    output logic        edge_1,
    output logic        edge_2,
    output logic        stalled
`ifdef HALL_GLITCH_CNT_EN
    ,
    output logic [15:0] glitch_cnt
`endif
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

    logic [1:0] raw, s, f, e, differ, done, abort;
    logic [SYNC_STAGES-1:0] sync [2];
    logic [CW-1:0] c [2];
    logic [TW-1:0] t;

    assign raw    = {hall_2_raw, hall_1_raw};
    assign hall_1 = f[0];
    assign hall_2 = f[1];
    assign edge_1 = e[0];
    assign edge_2 = e[1];

    // per-channel filter decisions: accept a level change or abort a pending one
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            s[i]      = sync[i][SYNC_STAGES-1];
            differ[i] = s[i] != f[i];
            done[i]   = differ[i] && c[i] == C_LAST;
            abort[i]  = !differ[i] && c[i] != '0;
        end
    end

    // synchronizer chains, stable-sample counters, filtered levels and edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                sync[i] <= '1;
                c[i]    <= '0;
            end
            f <= 2'b11;
            e <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync[i] <= {sync[i][SYNC_STAGES-2:0], raw[i]};
                c[i]    <= (!differ[i] || done[i]) ? '0 : c[i] + CW'(1);
                if (done[i]) f[i] <= s[i];
                e[i] <= done[i] & ~s[i];
            end
        end
    end

    // stall timer: cleared once by any filtered falling edge, saturates at the timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t       <= '0;
            stalled <= 1'b1;
        end else if (|e) begin
            t       <= '0;
            stalled <= 1'b0;
        end else if (t != T_MAX) begin
            t <= t + TW'(1);
            if (t == T_MAX - TW'(1)) stalled <= 1'b1;
        end
    end

`ifdef HALL_GLITCH_CNT_EN
    logic [16:0] gsum;
    assign gsum = 17'(glitch_cnt) + 17'(abort[0]) + 17'(abort[1]);

    // saturating count of aborted transitions across both channels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) glitch_cnt <= '0;
        else     glitch_cnt <= gsum[16] ? 16'hFFFF : gsum[15:0];
    end
`endif
endmodule
